// File: rtl/ahb_lite_mem_slave.sv
// rtl/ahb_lite_mem_slave.sv - AHB-Lite byte-addressable memory slave with wait states and two-cycle ERROR
module ahb_lite_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);
    localparam int AW    = $clog2(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;

    logic [AW-1:0] addr_q;
    logic [2:0]    size_q;
    logic          write_q;

    logic [7:0] mem [MEM_BYTES];

    logic [7:0]  req_bytes;
    logic [32:0] req_end;
    logic        req_err;
    logic        can_accept;
    logic        accept;

    logic [LANES-1:0] lane_en;
    logic [AW-1:0]    word_base;

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

    // Range check uses the full 32-bit address plus one carry bit so wrap-around is an error too.
    assign req_bytes = 8'd1 << HSIZE;
    assign req_end   = {1'b0, HADDR} + {25'd0, req_bytes};
    assign req_err   = (req_bytes > 8'(LANES))
                    || ((HADDR[7:0] & (req_bytes - 8'd1)) != 8'd0)
                    || (req_end > 33'(MEM_BYTES));

    assign can_accept = (state == S_IDLE) || (state == S_ACTIVE) || (state == S_ERR2);
    assign accept     = can_accept && HSEL && HREADY && HTRANS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && accept) begin
            addr_q  <= HADDR[AW-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            S_IDLE: ;
            S_WAIT: begin
                HREADYOUT = 1'b0;
                cnt_nx    = cnt - 3'd1;
                if (cnt == 3'd1) state_nx = S_ACTIVE;
            end
            S_ACTIVE: state_nx = S_IDLE;
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nx  = S_ERR2;
            end
            S_ERR2: begin
                HRESP    = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // A new address phase can only be taken while the slave is ready.
        if (accept) begin
            if (req_err) begin
                state_nx = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_nx = S_WAIT;
                cnt_nx   = 3'(WAIT_STATES);
            end else begin
                state_nx = S_ACTIVE;
            end
        end
    end

    always_comb begin
        int lo;
        int hi;
        lo        = int'(addr_q[LB-1:0]);
        hi        = lo + (1 << size_q);
        word_base = {addr_q[AW-1:LB], {LB{1'b0}}};
        for (int i = 0; i < LANES; i++) begin
            lane_en[i] = (i >= lo) && (i < hi);
        end
    end

    // Memory has no reset so contents survive HRESET.
    always_ff @(posedge HCLK) begin
        if (!HRESET && (state == S_ACTIVE) && write_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_en[i]) mem[word_base + AW'(i)] <= HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if ((state == S_ACTIVE) && !write_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_en[i]) HRDATA[8*i +: 8] = mem[word_base + AW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// tb/tb_ahb_lite_mem_slave.sv - directed scoreboard bench for ahb_lite_mem_slave (WAIT_STATES 1 and 0)
module tb_ahb_lite_mem_slave;

    logic        HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESET, HSEL, HWRITE, HMASTLOCK;
    logic [31:0] HADDR, HWDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    bit          use_b;

    logic        hsel_a, hsel_b;
    logic        hreadyout_a, hreadyout_b, hresp_a, hresp_b;
    logic [31:0] hrdata_a, hrdata_b;
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA;

    assign hsel_a    = HSEL & ~use_b;
    assign hsel_b    = HSEL & use_b;
    assign HREADYOUT = use_b ? hreadyout_b : hreadyout_a;
    assign HRESP     = use_b ? hresp_b : hresp_a;
    assign HRDATA    = use_b ? hrdata_b : hrdata_a;

    ahb_lite_mem_slave #(.DATA_WIDTH(32), .MEM_BYTES(1024), .WAIT_STATES(1)) u_dut_ws1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_a), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HREADY(hreadyout_a), .HWDATA(HWDATA), .HREADYOUT(hreadyout_a), .HRESP(hresp_a),
        .HRDATA(hrdata_a)
    );

    ahb_lite_mem_slave #(.DATA_WIDTH(32), .MEM_BYTES(1024), .WAIT_STATES(0)) u_dut_ws0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_b), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HREADY(hreadyout_b), .HWDATA(HWDATA), .HREADYOUT(hreadyout_b), .HRESP(hresp_b),
        .HRDATA(hrdata_b)
    );

    typedef struct {
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    op_t  ops[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   op_id    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [1:0] tr, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        op_t o;
        o.trans = tr; o.wr = wr; o.size = size; o.addr = addr;
        o.wdata = wdata; o.exp_rdata = exp_rdata; o.exp_err = exp_err;
        ops.push_back(o);
    endtask

    task automatic issue_next(output bit pending, output logic [31:0] pw);
        op_t  o;
        exp_t e;
        if (ops.size() > 0) begin
            o = ops.pop_front();
            HSEL = 1'b1; HTRANS = o.trans; HADDR = o.addr; HWRITE = o.wr; HSIZE = o.size;
            e.id    = op_id;
            e.rdata = o.exp_rdata;
            e.err   = o.exp_err;
            e.waits = o.exp_err ? 1 : (use_b ? 0 : 1);
            op_id++;
            sb.push_back(e);
            pending = 1'b1;
            pw      = o.wdata;
        end else begin
            HSEL = 1'b0; HTRANS = 2'd0;
            pending = 1'b0;
            pw      = '0;
        end
    endtask

    // Pipelined master: next address is driven during the current data phase.
    task automatic run_ops();
        bit          dphase, pending, r;
        int          waits, guard;
        logic [31:0] pend_wdata;
        exp_t        e;
        dphase = 1'b0;
        waits  = 0;
        issue_next(pending, pend_wdata);
        for (guard = 0; guard < 200; guard++) begin
            @(negedge HCLK);
            r = HREADYOUT;
            if (dphase) begin
                if (!r) begin
                    waits++;
                    chk($sformatf("op%0d_wait_hresp", sb[0].id), 32'(HRESP), 32'(sb[0].err));
                    chk($sformatf("op%0d_wait_hrdata", sb[0].id), HRDATA, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("op%0d_hresp", e.id), 32'(HRESP), 32'(e.err));
                    chk($sformatf("op%0d_hrdata", e.id), HRDATA, e.rdata);
                    chk($sformatf("op%0d_waits", e.id), 32'(waits), 32'(e.waits));
                end
            end
            if (r && !pending) break;
            @(posedge HCLK); #1;
            if (r) begin
                dphase = pending;
                waits  = 0;
                if (pending) HWDATA = pend_wdata;
                issue_next(pending, pend_wdata);
            end
        end
        chk("run_ops_completed", 32'(guard < 200), 32'd1);
        @(posedge HCLK); #1;
    endtask

    localparam logic [1:0] NS = 2'd2;
    localparam logic [1:0] SQ = 2'd3;

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'd0; HADDR = '0; HWRITE = 1'b0;
        HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0; HMASTLOCK = 1'b0; HWDATA = '0; use_b = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'h0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // BUSY with HSEL=1 starts nothing
        HSEL = 1'b1; HTRANS = 2'd1; HADDR = 32'h10; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0;
        @(negedge HCLK);
        chk("busy_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("busy_hresp", 32'(HRESP), 32'd0);
        @(posedge HCLK); #1;

        add(NS, 1'b1, 3'd2, 32'h10,  32'hA5A51234, 32'h0,        1'b0);
        add(NS, 1'b0, 3'd2, 32'h10,  32'h0,        32'hA5A51234, 1'b0);
        run_ops();

        add(NS, 1'b1, 3'd0, 32'h13,  32'h77000000, 32'h0,        1'b0);
        add(NS, 1'b0, 3'd2, 32'h10,  32'h0,        32'h77A51234, 1'b0);
        add(NS, 1'b0, 3'd1, 32'h12,  32'h0,        32'h77A50000, 1'b0);
        add(NS, 1'b0, 3'd0, 32'h11,  32'h0,        32'h00001200, 1'b0);
        run_ops();

        add(NS, 1'b1, 3'd2, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0);
        add(NS, 1'b1, 3'd2, 32'h400, 32'h11111111, 32'h0,        1'b1);
        add(NS, 1'b0, 3'd2, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0);
        add(NS, 1'b1, 3'd1, 32'h3FE, 32'hBEEF0000, 32'h0,        1'b0);
        add(NS, 1'b0, 3'd2, 32'h3FC, 32'h0,        32'hBEEFF00D, 1'b0);
        run_ops();

        add(NS, 1'b0, 3'd1, 32'h11,  32'h0,        32'h0,        1'b1);
        add(NS, 1'b0, 3'd3, 32'h20,  32'h0,        32'h0,        1'b1);
        add(NS, 1'b1, 3'd2, 32'h20,  32'h01020304, 32'h0,        1'b0);
        run_ops();

        // HRESET while the write to 0x20 sits in WAIT
        HSEL = 1'b1; HTRANS = NS; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0; HWDATA = 32'h5555AAAA; HRESET = 1'b1;
        @(negedge HCLK);
        chk("rstwait_in_wait", 32'(HREADYOUT), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rstwait_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rstwait_hresp", 32'(HRESP), 32'd0);
        @(posedge HCLK); #1;
        add(NS, 1'b0, 3'd2, 32'h20,  32'h0,        32'h01020304, 1'b0);
        run_ops();

        use_b  = 1'b1;
        HBURST = 3'b011;
        add(NS, 1'b1, 3'd2, 32'h40,  32'd1,        32'h0,        1'b0);
        add(SQ, 1'b1, 3'd2, 32'h44,  32'd2,        32'h0,        1'b0);
        add(SQ, 1'b1, 3'd2, 32'h48,  32'd3,        32'h0,        1'b0);
        add(SQ, 1'b1, 3'd2, 32'h4C,  32'd4,        32'h0,        1'b0);
        add(NS, 1'b0, 3'd2, 32'h40,  32'h0,        32'd1,        1'b0);
        add(SQ, 1'b0, 3'd2, 32'h44,  32'h0,        32'd2,        1'b0);
        add(SQ, 1'b0, 3'd2, 32'h48,  32'h0,        32'd3,        1'b0);
        add(SQ, 1'b0, 3'd2, 32'h4C,  32'h0,        32'd4,        1'b0);
        run_ops();

        HBURST = 3'b000;
        add(NS, 1'b1, 3'd2, 32'h42,  32'hDEADBEEF, 32'h0,        1'b1);
        add(NS, 1'b0, 3'd2, 32'h40,  32'h0,        32'd1,        1'b0);
        run_ops();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ahb_lite_mem_slave.md
AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning HWDATA/HRDATA width in bits (32 or 64).
REQ-002 The block SHALL have parameter MEM_BYTES, default 1024, meaning byte capacity (power of two, >= 1024).
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, meaning HREADYOUT-low cycles inserted per OKAY transfer (0..7).
REQ-004 Port list (name  direction  width  meaning): HCLK input 1 clock; HRESET input 1 reset; HSEL input 1 slave select; HADDR input 32 address; HWRITE input 1 write; HSIZE input 3 transfer size; HBURST input 3 burst type (ignored); HPROT input 4 protection (ignored); HTRANS input 2 transfer type; HMASTLOCK input 1 lock (ignored); HREADY input 1 bus ready; HWDATA input DATA_WIDTH write data; HREADYOUT output 1 slave ready; HRESP output 1 0=OKAY 1=ERROR; HRDATA output DATA_WIDTH read data.
REQ-005 One clock, HCLK; reset HRESET is synchronous and active-high.

Function
REQ-006 A transfer SHALL be accepted at a rising edge where HSEL=1, HREADY=1 and HTRANS is NONSEQ(2) or SEQ(3); HADDR, HSIZE, HWRITE are registered at that edge.
REQ-007 HTRANS IDLE(0) or BUSY(1) with HSEL=1, or HSEL=0, SHALL start no transfer and produce a zero-wait OKAY.
REQ-008 An accepted transfer SHALL be an error if: HSIZE bytes > DATA_WIDTH/8; HADDR not aligned to 2^HSIZE; or HADDR + 2^HSIZE > MEM_BYTES.
REQ-009 State machine: IDLE, WAIT, ACTIVE, ERR1, ERR2; reset state IDLE.
REQ-010 Accept of error transfer -> ERR1; OKAY transfer -> WAIT (counter loaded WAIT_STATES) if WAIT_STATES>0, else ACTIVE.
REQ-011 WAIT: HREADYOUT=0, HRESP=0, counter decrements each cycle; at counter==1 -> ACTIVE.
REQ-012 ACTIVE: HREADYOUT=1, HRESP=0; transfer completes at end of this cycle; new accept per REQ-006/010 in same cycle, else -> IDLE.
REQ-013 ERR1: HREADYOUT=0, HRESP=1; always -> ERR2.
REQ-014 ERR2: HREADYOUT=1, HRESP=1; new accept per REQ-006/010 allowed (master may cancel with IDLE), else -> IDLE.
REQ-015 IDLE: HREADYOUT=1, HRESP=0.
REQ-016 Write: at the ACTIVE edge, byte lanes L = HADDR[log2(DATA_WIDTH/8)-1:0] .. +2^HSIZE-1 of HWDATA SHALL be written to memory byte (word-aligned address + L), little-endian; other bytes unchanged.
REQ-017 Read: in ACTIVE, HRDATA SHALL present addressed byte lanes from current memory contents; unaddressed lanes 0.
REQ-018 A write completing in cycle N SHALL be visible to a read whose ACTIVE cycle is N+1 or later (back-to-back write->read same address returns new data).
REQ-019 HRDATA SHALL be 0 in IDLE, WAIT, ERR1, ERR2 and for write transfers.
REQ-020 Error transfers SHALL not modify memory.
REQ-021 SEQ transfers SHALL be handled identically to NONSEQ, each with its own WAIT_STATES and error check; burst boundaries not checked.
REQ-022 Address arithmetic SHALL use HADDR[log2(MEM_BYTES)-1:0] for indexing only after range check of full 32-bit HADDR.

Reset
REQ-023 While HRESET=1 at a rising edge: state IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0 from the following cycle.
REQ-024 Reset during WAIT or ERR1 SHALL abort the transfer with no memory write.
REQ-025 Memory contents SHALL be unaffected by reset.

Verification (DATA_WIDTH=32, MEM_BYTES=1024, WAIT_STATES=1)
REQ-026 Word write 0xA5A51234 to 0x10 then back-to-back word read 0x10 -> each HREADYOUT low 1 cycle, HRESP=0, read HRDATA=0xA5A51234.
REQ-027 Byte write HSIZE=0, HADDR=0x13, HWDATA=0x77000000, then word read 0x10 -> HRDATA=0x77A51234; halfword read 0x12 -> HRDATA=0x77A50000.
REQ-028 Word write to 0x400 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, then OKAY; read 0x3FC unchanged.
REQ-029 Halfword read at 0x11 and HSIZE=3 at 0x20 -> two-cycle ERROR each; HRDATA=0.
REQ-030 HRESET=1 during WAIT of word write 0x5555AAAA to 0x20 (old 0x01020304) -> HREADYOUT=1 next cycle; read 0x20 returns 0x01020304.
REQ-031 INCR4 SEQ burst writes 0x40..0x4C (values 1..4) with WAIT_STATES=0 -> HREADYOUT constantly 1, readback 1..4.
